// File: rtl/seg_disp_pkg.sv
// Shared encodings for the seven-segment display scheduler.
package seg_disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MSG   = 2'd1;
    localparam logic [1:0] ST_ALARM = 2'd2;

    localparam logic [1:0] SRC_BG    = 2'd0;
    localparam logic [1:0] SRC_MSG   = 2'd1;
    localparam logic [1:0] SRC_ALARM = 2'd2;

    localparam logic [7:0] ALL_ON = 8'hFF;

endpackage

// File: rtl/disp_blink_gen.sv
// Blink phase generator; phase_on is the phase for the cycle being registered this edge.
module disp_blink_gen #(
    parameter int unsigned BLINK_CNT = 25_000_000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_on
);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    assign phase_on = phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/seg_disp_scheduler.sv
// Arbitrates background, timed message and alarm content for the 8-digit display driver.
module seg_disp_scheduler
    import seg_disp_pkg::*;
#(
    parameter int unsigned HOLD_CNT  = 100_000_000,
    parameter int unsigned BLINK_CNT = 25_000_000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bg_data,
    input  logic [7:0]  bg_able,
    input  logic        msg_req,
    input  logic [31:0] msg_data,
    input  logic [7:0]  msg_able,
    input  logic        msg_blink,
    output logic        msg_ack,
    output logic        msg_busy,
    input  logic        alarm,
    input  logic [31:0] alarm_data,
    output logic [31:0] dispdata,
    output logic [7:0]  seg_able,
    output logic [1:0]  src
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             busy_q, busy_d;
    logic [31:0]      mdata_q, mdata_d;
    logic [7:0]       mable_q, mable_d;
    logic             mblink_q, mblink_d;
    logic [31:0]      disp_q, disp_d;
    logic [7:0]       able_q, able_d;
    logic [1:0]       src_q, src_d;
    logic             ack_q;
    logic             restart;
    logic             phase_on;

    // hold_q is the index of the message cycle on display; leaving MSG for ALARM
    // counts the cycle just shown so the resume picks up at the next index.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        mdata_d  = mdata_q;
        mable_d  = mable_q;
        mblink_d = mblink_q;
        if (msg_req) begin
            mdata_d  = msg_data;
            mable_d  = msg_able;
            mblink_d = msg_blink;
            hold_d   = '0;
            busy_d   = 1'b1;
        end
        if (alarm) state_d = ST_ALARM;
        case (state_q)
            ST_IDLE: begin
                if (!alarm && msg_req) state_d = ST_MSG;
            end
            ST_MSG: begin
                if (!msg_req) begin
                    if (hold_q == HOLD_LAST) begin
                        busy_d = 1'b0;
                        if (!alarm) state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                if (!alarm) state_d = busy_d ? ST_MSG : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign restart = (state_d != state_q) && (state_d == ST_MSG || state_d == ST_ALARM);

    disp_blink_gen #(
        .BLINK_CNT (BLINK_CNT),
        .CNT_W     (CNT_W)
    ) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .phase_on (phase_on)
    );

    always_comb begin
        disp_d = bg_data;
        able_d = bg_able;
        src_d  = SRC_BG;
        case (state_d)
            ST_MSG: begin
                disp_d = mdata_d;
                able_d = (mblink_d && !phase_on) ? '0 : mable_d;
                src_d  = SRC_MSG;
            end
            ST_ALARM: begin
                disp_d = alarm_data;
                able_d = phase_on ? ALL_ON : '0;
                src_d  = SRC_ALARM;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            mdata_q  <= '0;
            mable_q  <= '0;
            mblink_q <= 1'b0;
            disp_q   <= '0;
            able_q   <= '0;
            src_q    <= SRC_BG;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            mdata_q  <= mdata_d;
            mable_q  <= mable_d;
            mblink_q <= mblink_d;
            disp_q   <= disp_d;
            able_q   <= able_d;
            src_q    <= src_d;
            ack_q    <= msg_req;
        end
    end

    assign dispdata = disp_q;
    assign seg_able = able_q;
    assign src      = src_q;
    assign msg_ack  = ack_q;
    assign msg_busy = busy_q;

endmodule

// File: tb/tb_seg_disp_scheduler.sv
// Directed bench for seg_disp_scheduler with HOLD_CNT=10, BLINK_CNT=3.
module tb_seg_disp_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bg_data;
    logic [7:0]  bg_able;
    logic        msg_req;
    logic [31:0] msg_data;
    logic [7:0]  msg_able;
    logic        msg_blink;
    logic        msg_ack;
    logic        msg_busy;
    logic        alarm;
    logic [31:0] alarm_data;
    logic [31:0] dispdata;
    logic [7:0]  seg_able;
    logic [1:0]  src;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    seg_disp_scheduler #(
        .HOLD_CNT  (10),
        .BLINK_CNT (3),
        .CNT_W     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bg_data    (bg_data),
        .bg_able    (bg_able),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .msg_able   (msg_able),
        .msg_blink  (msg_blink),
        .msg_ack    (msg_ack),
        .msg_busy   (msg_busy),
        .alarm      (alarm),
        .alarm_data (alarm_data),
        .dispdata   (dispdata),
        .seg_able   (seg_able),
        .src        (src)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] e_src, input logic [31:0] e_disp,
                           input logic [7:0] e_able, input logic e_ack, input logic e_busy);
        chk({tag, ".src"},  {30'd0, src},      {30'd0, e_src});
        chk({tag, ".disp"}, dispdata,          e_disp);
        chk({tag, ".able"}, {24'd0, seg_able}, {24'd0, e_able});
        chk({tag, ".ack"},  {31'd0, msg_ack},  {31'd0, e_ack});
        chk({tag, ".busy"}, {31'd0, msg_busy}, {31'd0, e_busy});
    endtask

    initial begin
        rst_n      = 1'b0;
        bg_data    = 32'h00001234;
        bg_able    = 8'h0F;
        msg_req    = 1'b0;
        msg_data   = '0;
        msg_able   = '0;
        msg_blink  = 1'b0;
        alarm      = 1'b0;
        alarm_data = 32'hDEADBEEF;

        // 1: reset state and background
        step(); step();
        chk_out("reset", 2'd0, 32'h0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("bg", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);

        // 2: plain message, 10 cycles
        msg_req = 1'b1; msg_data = 32'hCAFE0000; msg_able = 8'hF0; msg_blink = 1'b0;
        step();
        chk_out("msg_first", 2'd1, 32'hCAFE0000, 8'hF0, 1'b1, 1'b1);
        msg_req = 1'b0;
        for (int i = 1; i < 10; i++) begin
            step();
            chk_out($sformatf("msg_hold%0d", i), 2'd1, 32'hCAFE0000, 8'hF0, 1'b0, 1'b1);
        end
        step();
        chk_out("msg_done", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);

        // 3: blinking message F0 x3, 00 x3, ...
        msg_req = 1'b1; msg_data = 32'h12345678; msg_able = 8'hF0; msg_blink = 1'b1;
        step();
        msg_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_out($sformatf("blink%0d", i), 2'd1, 32'h12345678,
                    (((i / 3) % 2) == 0) ? 8'hF0 : 8'h00, (i == 0) ? 1'b1 : 1'b0, 1'b1);
            step();
        end
        chk_out("blink_done", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);

        // 4: alarm 4 clks into a message, held 5 clks, then 6 remaining message clks
        msg_req = 1'b1; msg_data = 32'hCAFE0000; msg_able = 8'hF0; msg_blink = 1'b0;
        step();
        msg_req = 1'b0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk_out($sformatf("pre_alarm%0d", i), 2'd1, 32'hCAFE0000, 8'hF0, 1'b0, 1'b1);
        end
        alarm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("alarm%0d", i), 2'd2, 32'hDEADBEEF,
                    (((i / 3) % 2) == 0) ? 8'hFF : 8'h00, 1'b0, 1'b1);
        end
        alarm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_out($sformatf("resume%0d", i), 2'd1, 32'hCAFE0000, 8'hF0, 1'b0, 1'b1);
        end
        step();
        chk_out("resume_done", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);

        // 5: request coincident with alarm rise
        alarm = 1'b1; msg_req = 1'b1; msg_data = 32'h0BADF00D; msg_able = 8'h3C; msg_blink = 1'b0;
        step();
        chk_out("coinc", 2'd2, 32'hDEADBEEF, 8'hFF, 1'b1, 1'b1);
        msg_req = 1'b0;
        step();
        chk_out("coinc_alarm", 2'd2, 32'hDEADBEEF, 8'hFF, 1'b0, 1'b1);
        alarm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out($sformatf("coinc_msg%0d", i), 2'd1, 32'h0BADF00D, 8'h3C, 1'b0, 1'b1);
        end
        step();
        chk_out("coinc_done", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);

        // 6: async reset mid-message
        msg_req = 1'b1; msg_data = 32'hCAFE0000; msg_able = 8'hF0; msg_blink = 1'b0;
        step();
        msg_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk_out("pre_rst", 2'd1, 32'hCAFE0000, 8'hF0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 2'd0, 32'h0, 8'h00, 1'b0, 1'b0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk_out("post_rst", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);
        step();
        chk_out("post_rst2", 2'd0, 32'h00001234, 8'h0F, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
